// File: rtl/wishbone_rr_arbiter.sv
// ============================================================================
// Module   : wishbone_rr_arbiter
// Purpose  : Round-robin arbiter that shares one Wishbone classic slave port
//            between NUM_MASTERS masters. The grant is held for the whole CYC.
//            Optional watchdog is enabled with `define WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_MASTERS-1:0]                M_CYC,
    input  logic [NUM_MASTERS-1:0]                M_STB,
    input  logic [NUM_MASTERS-1:0]                M_WE,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     M_ADDR,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_WDATA,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   M_SEL,
    output logic [DATA_WIDTH-1:0]                 M_RDATA,
    output logic [NUM_MASTERS-1:0]                M_ACK,
    output logic [NUM_MASTERS-1:0]                M_ERR,
    output logic [NUM_MASTERS-1:0]                GRANT,
    output logic                                  WB_CYC,
    output logic                                  WB_STB,
    output logic                                  WB_WE,
    output logic [ADDR_WIDTH-1:0]                 WB_ADDR,
    output logic [DATA_WIDTH-1:0]                 WB_WDATA,
    output logic [DATA_WIDTH/8-1:0]               WB_SEL,
    input  logic [DATA_WIDTH-1:0]                 WB_RDATA,
    input  logic                                  WB_ACK
);

    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_SEL_W = DATA_WIDTH / 8;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   w_grant_next;
    logic [c_IDX_W-1:0]       r_last;
    logic [c_IDX_W-1:0]       w_last_next;
    logic [c_IDX_W-1:0]       w_pick;
    logic                     w_found;
    logic [NUM_MASTERS-1:0]   w_req;
    logic                     w_cyc_g;
    logic                     w_stb_g;
    logic                     w_timeout;

    assign w_req   = M_CYC & M_STB;
    assign w_cyc_g = |(M_CYC & r_grant);
    assign w_stb_g = |(M_STB & r_grant);

    // Two descending passes: the lowest requester above r_last wins,
    // otherwise the lowest requester at or below it (wrap-around).
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_req[i] && (c_IDX_W'(i) <= r_last)) begin
                w_pick  = c_IDX_W'(i);
                w_found = 1'b1;
            end
        end
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_req[i] && (c_IDX_W'(i) > r_last)) begin
                w_pick  = c_IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= c_LAST_IDX;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        case (r_state)
            S_IDLE: begin
                w_grant_next = '0;
                if (w_found) begin
                    w_state_next = S_BUSY;
                    w_last_next  = w_pick;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        w_grant_next[i] = (w_pick == c_IDX_W'(i));
                    end
                end
            end
            S_BUSY: begin
                if (!w_cyc_g || w_timeout) begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    // r_grant is zero in IDLE, so the AND-OR mux also zeroes idle outputs.
    always_comb begin
        WB_WE    = 1'b0;
        WB_ADDR  = '0;
        WB_WDATA = '0;
        WB_SEL   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            WB_WE    = WB_WE    | (M_WE[i] & r_grant[i]);
            WB_ADDR  = WB_ADDR  | (M_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}});
            WB_WDATA = WB_WDATA | (M_WDATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
            WB_SEL   = WB_SEL   | (M_SEL[i*c_SEL_W +: c_SEL_W] & {c_SEL_W{r_grant[i]}});
        end
    end

    assign GRANT   = r_grant;
    assign WB_CYC  = w_cyc_g & ~w_timeout;
    assign WB_STB  = w_stb_g & ~w_timeout;
    assign M_ACK   = r_grant & M_STB & {NUM_MASTERS{WB_ACK & ~w_timeout}};
    assign M_RDATA = WB_RDATA;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_IDLE) || WB_ACK) begin
            r_tmo_cnt <= '0;
        end else if (WB_STB) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_BUSY) && (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYCLES));
    assign M_ERR     = r_grant & {NUM_MASTERS{w_timeout}};
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_timeout    = 1'b0;
    assign M_ERR        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wishbone_rr_arbiter.sv
// ============================================================================
// Module   : tb_wishbone_rr_arbiter
// Purpose  : Directed self-checking bench for wishbone_rr_arbiter (2 masters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [NM-1:0]     m_we;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*DW/8-1:0] m_sel;
    logic [DW-1:0]     m_rdata;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic [NM-1:0]     grant;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_wdata;
    logic [DW/8-1:0]   wb_sel;
    logic [DW-1:0]     wb_rdata;
    logic              wb_ack;

    int n_pass;
    int n_total;

    wishbone_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .M_CYC    (m_cyc),
        .M_STB    (m_stb),
        .M_WE     (m_we),
        .M_ADDR   (m_addr),
        .M_WDATA  (m_wdata),
        .M_SEL    (m_sel),
        .M_RDATA  (m_rdata),
        .M_ACK    (m_ack),
        .M_ERR    (m_err),
        .GRANT    (grant),
        .WB_CYC   (wb_cyc),
        .WB_STB   (wb_stb),
        .WB_WE    (wb_we),
        .WB_ADDR  (wb_addr),
        .WB_WDATA (wb_wdata),
        .WB_SEL   (wb_sel),
        .WB_RDATA (wb_rdata),
        .WB_ACK   (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_sel    = '0;
        wb_rdata = '0;
        wb_ack   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            if ({grant, wb_cyc, wb_stb, wb_we, m_ack, m_err, wb_addr, wb_wdata, wb_sel} !== '0) begin
                $display("FAIL reset_idle cycle %0d: grant=%b cyc=%b stb=%b ack=%b err=%b addr=%h, want all zero",
                         c, grant, wb_cyc, wb_stb, m_ack, m_err, wb_addr);
            end else n_pass++;
            n_total++;
            next_cycle();
        end
    endtask

    task automatic test_write();
        apply_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_addr[0 +: AW]  = 32'h0000_1000;
        m_wdata[0 +: DW] = 32'hDEAD_BEEF;
        m_sel[0 +: 4]    = 4'hF;
        #1;
        if (wb_cyc !== 1'b0) begin
            $display("FAIL write_latency0: WB_CYC=%b, want 0", wb_cyc);
        end else n_pass++;
        n_total++;
        next_cycle();
        #1;
        if ({grant, wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel} !==
            {2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
            $display("FAIL write_cycle1: grant=%b cyc=%b stb=%b we=%b addr=%h data=%h sel=%h, want 01 1 1 1 00001000 deadbeef f",
                     grant, wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel);
        end else n_pass++;
        n_total++;
        if (m_ack !== 2'b00) begin
            $display("FAIL write_wait1: M_ACK=%b, want 00", m_ack);
        end else n_pass++;
        n_total++;
        next_cycle();
        #1;
        if (m_ack !== 2'b00) begin
            $display("FAIL write_wait2: M_ACK=%b, want 00", m_ack);
        end else n_pass++;
        n_total++;
        next_cycle();
        wb_ack = 1'b1;
        #1;
        if (m_ack !== 2'b01) begin
            $display("FAIL write_ack: M_ACK=%b, want 01", m_ack);
        end else n_pass++;
        n_total++;
        next_cycle();
        wb_ack = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        #1;
        if ({grant, wb_cyc} !== {2'b01, 1'b0}) begin
            $display("FAIL write_cyc_drop: grant=%b cyc=%b, want 01 0", grant, wb_cyc);
        end else n_pass++;
        n_total++;
        next_cycle();
        wb_ack = 1'b1;
        #1;
        if ({grant, wb_cyc, m_ack, wb_addr} !== {2'b00, 1'b0, 2'b00, 32'h0}) begin
            $display("FAIL write_idle_ack: grant=%b cyc=%b ack=%b addr=%h, want 00 0 00 0",
                     grant, wb_cyc, m_ack, wb_addr);
        end else n_pass++;
        n_total++;
        wb_ack = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        next_cycle();
        #1;
        if (grant !== 2'b01) begin
            $display("FAIL simul_first: GRANT=%b, want 01", grant);
        end else n_pass++;
        n_total++;
        wb_ack = 1'b1;
        next_cycle();
        wb_ack = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        next_cycle();
        #1;
        if (grant !== 2'b00) begin
            $display("FAIL simul_idle_gap: GRANT=%b, want 00", grant);
        end else n_pass++;
        n_total++;
        next_cycle();
        #1;
        if (grant !== 2'b10) begin
            $display("FAIL simul_second: GRANT=%b, want 10", grant);
        end else n_pass++;
        n_total++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int g;
        logic [NM-1:0] exp_grant;
        apply_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int t = 0; t < 6; t++) begin
            int waited;
            waited = 0;
            while (grant === 2'b00 && waited < 10) begin
                next_cycle();
                #1;
                waited++;
            end
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
            if (grant !== exp_grant) begin
                $display("FAIL rr_order txn %0d: GRANT=%b, want %b", t, grant, exp_grant);
            end else n_pass++;
            n_total++;
            g = (grant === 2'b10) ? 1 : 0;
            wb_ack = 1'b1;
            #1;
            if (m_ack !== exp_grant) begin
                $display("FAIL rr_ack txn %0d: M_ACK=%b, want %b", t, m_ack, exp_grant);
            end else n_pass++;
            n_total++;
            next_cycle();
            wb_ack = 1'b0;
            m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
            next_cycle();
            m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_read();
        apply_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_addr[AW +: AW] = 32'h0000_2000;
        next_cycle();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        wb_rdata = 32'hCAFE_F00D;
        wb_ack   = 1'b1;
        #1;
        if ({grant, m_ack, m_rdata, wb_addr, wb_we} !== {2'b10, 2'b10, 32'hCAFE_F00D, 32'h0000_2000, 1'b0}) begin
            $display("FAIL read_ack: grant=%b ack=%b rdata=%h addr=%h we=%b, want 10 10 cafef00d 00002000 0",
                     grant, m_ack, m_rdata, wb_addr, wb_we);
        end else n_pass++;
        n_total++;
        next_cycle();
        m_stb[1] = 1'b0;
        #1;
        if ({grant, m_ack} !== {2'b10, 2'b00}) begin
            $display("FAIL read_ack_no_stb: grant=%b ack=%b, want 10 00", grant, m_ack);
        end else n_pass++;
        n_total++;
        next_cycle();
        wb_ack = 1'b0;
        m_cyc[1] = 1'b0;
        next_cycle();
        #1;
        if (grant !== 2'b00) begin
            $display("FAIL read_idle_gap: GRANT=%b, want 00", grant);
        end else n_pass++;
        n_total++;
        next_cycle();
        #1;
        if (grant !== 2'b01) begin
            $display("FAIL read_waiter_granted: GRANT=%b, want 01", grant);
        end else n_pass++;
        n_total++;
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        apply_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        next_cycle();
        #1;
        if (grant !== 2'b10) begin
            $display("FAIL rstbusy_grant: GRANT=%b, want 10", grant);
        end else n_pass++;
        n_total++;
        rst = 1'b1;
        next_cycle();
        #1;
        if ({grant, wb_cyc, m_ack} !== {2'b00, 1'b0, 2'b00}) begin
            $display("FAIL rstbusy_drop: grant=%b cyc=%b ack=%b, want 00 0 00", grant, wb_cyc, m_ack);
        end else n_pass++;
        n_total++;
        rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        next_cycle();
        #1;
        if (grant !== 2'b01) begin
            $display("FAIL rstbusy_priority: GRANT=%b, want 01", grant);
        end else n_pass++;
        n_total++;
        clear_inputs();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            #1;
            if ({m_err, wb_cyc} !== {2'b00, 1'b1}) begin
                $display("FAIL tmo_wait cycle %0d: err=%b cyc=%b, want 00 1", c, m_err, wb_cyc);
            end else n_pass++;
            n_total++;
        end
        next_cycle();
        #1;
        if ({m_err, wb_cyc, wb_stb} !== {2'b01, 1'b0, 1'b0}) begin
            $display("FAIL tmo_fire: err=%b cyc=%b stb=%b, want 01 0 0", m_err, wb_cyc, wb_stb);
        end else n_pass++;
        n_total++;
        next_cycle();
        #1;
        if ({grant, m_err} !== {2'b00, 2'b00}) begin
            $display("FAIL tmo_idle: grant=%b err=%b, want 00 00", grant, m_err);
        end else n_pass++;
        n_total++;
        clear_inputs();
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_write();
        test_simultaneous();
        test_back_to_back();
        test_read();
        test_reset_busy();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
